// File: rtl/core_inst_sequencer_if.sv
// Sequencer-side signals: run request and OFIFO status in, core instruction word and run status out.
// The slave modport is the sequencer; the master modport is the controller/core side driving it.
interface core_inst_sequencer_if #(
    parameter int col = 8
);
    logic           start_i;
    logic [col-1:0] ofifo_valid_i;
    logic [33:0]    inst_o;
    logic           busy_o;
    logic           done_o;

    modport slave (
        input  start_i,
        input  ofifo_valid_i,
        output inst_o,
        output busy_o,
        output done_o
    );

    modport master (
        output start_i,
        output ofifo_valid_i,
        input  inst_o,
        input  busy_o,
        input  done_o
    );
endinterface

// File: rtl/core_inst_sequencer.sv
// Layer sequencer: one start runs weight load, execute and OFIFO->pmem drain for every kij.
// Define SEQ_ACC_EN to append a pmem accumulation pass over all kij partial sums before done.
module core_inst_sequencer #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int N_ACT    = 36,
    parameter int N_KIJ    = 9,
    parameter int ACT_BASE = 0,
    parameter int W_BASE   = 1024,
    parameter int P_BASE   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    core_inst_sequencer_if.slave bus
);
    localparam logic [15:0] COL_L  = 16'(col);
    localparam logic [15:0] WAIT_L = 16'(row + col);
    localparam logic [15:0] NACT_L = 16'(N_ACT);
    localparam logic [15:0] NKIJ_L = 16'(N_KIJ);
    localparam logic [33:0] IDLE_WORD = {3'b011, 11'd0, 2'b11, 11'd0, 7'd0};

    localparam int W_TOP = W_BASE + N_KIJ * col - 1;
    localparam int X_TOP = ACT_BASE + N_ACT - 1;
`ifdef SEQ_ACC_EN
    localparam int P_TOP = P_BASE + (N_KIJ + 1) * N_ACT - 1;
`else
    localparam int P_TOP = P_BASE + N_KIJ * N_ACT - 1;
`endif

    if (W_TOP > 2047 || X_TOP > 2047 || P_TOP > 2047) begin : g_addr_range
        $error("core_inst_sequencer: parameters push an address beyond 11 bits");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_W_XRD, S_W_LOAD, S_W_WAIT, S_EXEC, S_DRAIN,
`ifdef SEQ_ACC_EN
        S_ACC_RD, S_ACC_WR,
`endif
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, kij_q, kij_d;
    logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_base, wr_base;
    logic        pend;
    logic [33:0] inst_q, inst_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        cen_x, cen_p, wen_p, ofifo_rd, l0_rd, l0_wr, execute, load, acc;
    logic [10:0] a_x, a_p;
`ifdef SEQ_ACC_EN
    logic [15:0] out_q, out_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        kij_d    = kij_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        rd_base  = '0;
        wr_base  = '0;
        pend     = 1'b0;
`ifdef SEQ_ACC_EN
        out_d    = out_q;
`endif
        case (state_q)
            S_IDLE: if (bus.start_i) begin
                state_d = S_W_XRD;
                cnt_d   = '0;
                kij_d   = '0;
            end
            S_W_XRD: if (cnt_q == COL_L) begin
                state_d = S_W_LOAD;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 16'd1;
            S_W_LOAD: if (cnt_q == COL_L - 16'd1) begin
                state_d = S_W_WAIT;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 16'd1;
            S_W_WAIT: if (cnt_q == WAIT_L - 16'd1) begin
                state_d = S_EXEC;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 16'd1;
            S_EXEC: if (cnt_q == NACT_L) begin
                state_d = S_DRAIN;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 16'd1;
            S_DRAIN: begin
                // a pmem write always trails the ofifo_rd issued one cycle earlier
                rd_base = rd_cnt_q;
                wr_base = wr_cnt_q;
                pend    = inst_q[6];
                if (wr_cnt_q == NACT_L) begin
                    cnt_d = '0;
                    if (kij_q != NKIJ_L - 16'd1) begin
                        kij_d   = kij_q + 16'd1;
                        state_d = S_W_XRD;
                    end else begin
`ifdef SEQ_ACC_EN
                        state_d = S_ACC_RD;
                        out_d   = '0;
`else
                        state_d = S_FIN;
`endif
                    end
                end
            end
`ifdef SEQ_ACC_EN
            S_ACC_RD: if (cnt_q == NKIJ_L - 16'd1) begin
                state_d = S_ACC_WR;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 16'd1;
            S_ACC_WR: if (out_q == NACT_L - 16'd1) begin
                state_d = S_FIN;
            end else begin
                out_d   = out_q + 16'd1;
                state_d = S_ACC_RD;
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        cen_x    = 1'b1;
        a_x      = '0;
        cen_p    = 1'b1;
        wen_p    = 1'b1;
        a_p      = '0;
        ofifo_rd = 1'b0;
        l0_rd    = 1'b0;
        l0_wr    = 1'b0;
        execute  = 1'b0;
        load     = 1'b0;
        acc      = 1'b0;
        case (state_d)
            S_W_XRD: begin
                if (cnt_d < COL_L) begin
                    cen_x = 1'b0;
                    a_x   = 11'(W_BASE + int'(kij_d) * col + int'(cnt_d));
                end
                l0_wr = (cnt_d != 16'd0);
            end
            S_W_LOAD: begin
                l0_rd = 1'b1;
                load  = 1'b1;
            end
            S_EXEC: begin
                if (cnt_d < NACT_L) begin
                    cen_x = 1'b0;
                    a_x   = 11'(ACT_BASE + int'(cnt_d));
                end
                l0_wr   = (cnt_d != 16'd0);
                l0_rd   = (cnt_d != 16'd0);
                execute = (cnt_d != 16'd0);
            end
            S_DRAIN: begin
                ofifo_rd = (&bus.ofifo_valid_i) && (rd_base < NACT_L);
                if (pend) begin
                    cen_p = 1'b0;
                    wen_p = 1'b0;
                    a_p   = 11'(P_BASE + int'(kij_d) * N_ACT + int'(wr_base));
                end
                rd_cnt_d = rd_base + {15'd0, ofifo_rd};
                wr_cnt_d = wr_base + {15'd0, pend};
            end
`ifdef SEQ_ACC_EN
            S_ACC_RD: begin
                cen_p = 1'b0;
                acc   = 1'b1;
                a_p   = 11'(P_BASE + int'(cnt_d) * N_ACT + int'(out_d));
            end
            S_ACC_WR: begin
                cen_p = 1'b0;
                wen_p = 1'b0;
                acc   = 1'b1;
                a_p   = 11'(P_BASE + N_KIJ * N_ACT + int'(out_d));
            end
`endif
            default: ;
        endcase

        inst_d = {acc, cen_p, wen_p, a_p, cen_x, 1'b1, a_x,
                  ofifo_rd, 2'b00, l0_rd, l0_wr, execute, load};
        busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            kij_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            inst_q   <= IDLE_WORD;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_ACC_EN
            out_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kij_q    <= kij_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            inst_q   <= inst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SEQ_ACC_EN
            out_q    <= out_d;
`endif
        end
    end

    assign bus.inst_o = inst_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
endmodule

// File: tb/tb_core_inst_sequencer.sv
// Bench for core_inst_sequencer: a phase-by-phase behavioural model predicts every output cycle,
// and literal checks pin reset, weight load, execute, drain backpressure and run completion.
module tb_core_inst_sequencer;
    localparam int ROW = 8, COL = 8, N_ACT = 36, N_KIJ = 9;
    localparam int ACT_BASE = 0, W_BASE = 1024, P_BASE = 0;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
    localparam int TMAX = 8192;
    localparam int PH_IDLE = 0, PH_WX = 1, PH_WL = 2, PH_WW = 3, PH_EX = 4, PH_DR = 5, PH_ACC = 6;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start_drv = 1'b0;
    logic [COL-1:0] ofv = '1;

    core_inst_sequencer_if #(.col(COL)) bus();
    assign bus.start_i       = start_drv;
    assign bus.ofifo_valid_i = ofv;

    core_inst_sequencer #(
        .row(ROW), .col(COL), .N_ACT(N_ACT), .N_KIJ(N_KIJ),
        .ACT_BASE(ACT_BASE), .W_BASE(W_BASE), .P_BASE(P_BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [33:0] exp_inst = IDLE_W;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    bit          m_abort  = 1'b0;
    int          m_ph = PH_IDLE, m_kij = 0, m_cnt = 0;

    always @(posedge reset) begin
        m_abort  = 1'b1;
        m_ph     = PH_IDLE;
        exp_inst = IDLE_W;
        exp_busy = 1'b0;
        exp_done = 1'b0;
    end

    task automatic cyc(input logic [33:0] w, input logic b, input logic d);
        exp_inst = w;
        exp_busy = b;
        exp_done = d;
        @(posedge clk);
    endtask

    task automatic run_layer();
        logic [33:0] w;
        int  reads, writes;
        bit  rd, prev_rd;
        m_abort = 1'b0;
        for (int k = 0; k < N_KIJ; k++) begin
            m_kij = k;
            m_ph  = PH_WX;
            for (int c = 0; c <= COL; c++) begin
                m_cnt = c;
                w = IDLE_W;
                if (c < COL) begin
                    w[19]   = 1'b0;
                    w[17:7] = 11'(W_BASE + k * COL + c);
                end
                if (c >= 1) w[2] = 1'b1;
                cyc(w, 1'b1, 1'b0);
                if (m_abort) return;
            end
            m_ph = PH_WL;
            for (int c = 0; c < COL; c++) begin
                m_cnt = c;
                w = IDLE_W;
                w[3] = 1'b1;
                w[0] = 1'b1;
                cyc(w, 1'b1, 1'b0);
                if (m_abort) return;
            end
            m_ph = PH_WW;
            for (int c = 0; c < ROW + COL; c++) begin
                m_cnt = c;
                cyc(IDLE_W, 1'b1, 1'b0);
                if (m_abort) return;
            end
            m_ph = PH_EX;
            for (int c = 0; c <= N_ACT; c++) begin
                m_cnt = c;
                w = IDLE_W;
                if (c < N_ACT) begin
                    w[19]   = 1'b0;
                    w[17:7] = 11'(ACT_BASE + c);
                end
                if (c >= 1) w[3:1] = 3'b111;
                cyc(w, 1'b1, 1'b0);
                if (m_abort) return;
            end
            m_ph = PH_DR;
            reads = 0; writes = 0; prev_rd = 1'b0;
            while (writes < N_ACT) begin
                m_cnt = writes;
                w  = IDLE_W;
                rd = (ofv == 8'hFF) && (reads < N_ACT);
                if (rd) begin
                    w[6] = 1'b1;
                    reads++;
                end
                if (prev_rd) begin
                    w[32]    = 1'b0;
                    w[31]    = 1'b0;
                    w[30:20] = 11'(P_BASE + k * N_ACT + writes);
                    writes++;
                end
                prev_rd = rd;
                cyc(w, 1'b1, 1'b0);
                if (m_abort) return;
            end
        end
`ifdef SEQ_ACC_EN
        m_ph = PH_ACC;
        for (int o = 0; o < N_ACT; o++) begin
            for (int k = 0; k < N_KIJ; k++) begin
                w = IDLE_W;
                w[33]    = 1'b1;
                w[32]    = 1'b0;
                w[30:20] = 11'(P_BASE + k * N_ACT + o);
                cyc(w, 1'b1, 1'b0);
                if (m_abort) return;
            end
            w = IDLE_W;
            w[33]    = 1'b1;
            w[32]    = 1'b0;
            w[31]    = 1'b0;
            w[30:20] = 11'(P_BASE + N_KIJ * N_ACT + o);
            cyc(w, 1'b1, 1'b0);
            if (m_abort) return;
        end
`endif
        m_ph = PH_IDLE;
        cyc(IDLE_W, 1'b0, 1'b1);
        exp_inst = IDLE_W;
        exp_busy = 1'b0;
        exp_done = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!reset && start_drv) run_layer();
        end
    end

    // ---------------- per-cycle compare and trace ----------------
    logic [33:0] tr_inst [TMAX];
    logic        tr_done [TMAX];
    logic [7:0]  tr_val  [TMAX];
    int          tr_n = 0;
    bit          tr_en = 1'b0;
    int          done_cnt = 0;

    always @(posedge clk) begin
        #1;
        check("cycle_outputs", {bus.inst_o, bus.busy_o, bus.done_o},
              {exp_inst, exp_busy, exp_done});
        if (bus.done_o) done_cnt++;
        if (tr_en && tr_n < TMAX) begin
            tr_inst[tr_n] = bus.inst_o;
            tr_done[tr_n] = bus.done_o;
            tr_val[tr_n]  = ofv;
            tr_n++;
        end
    end

    task automatic wait_phase(input int ph, input int k, input int c, output bit found);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (m_ph == ph && m_kij == k && m_cnt == c) found = 1'b1;
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        bit found;
        int idx, bad, nw, last_w;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_inst", bus.inst_o, 34'h1_800C_0000);
        check("reset_busy", bus.busy_o, 0);
        check("reset_done", bus.done_o, 0);
        reset = 1'b0;
        @(negedge clk);

        // run aborted by reset in the middle of kij 0 execute
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        check("run1_busy_after_start", bus.busy_o, 1);
        wait_phase(PH_EX, 0, 10, found);
        check("run1_reach_exec", found, 1);
        reset = 1'b1;
        #1;
        check("midrst_inst", bus.inst_o, 34'h1_800C_0000);
        check("midrst_busy", bus.busy_o, 0);
        check("midrst_done", bus.done_o, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("midrst_no_done_pulse", done_cnt, 0);
        repeat (2) @(negedge clk);

        // full run with a repeated start while busy and drain backpressure at kij 2
        done_cnt  = 0;
        tr_n      = 0;
        tr_en     = 1'b1;
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        repeat (4) @(negedge clk);
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        wait_phase(PH_EX, 2, N_ACT, found);
        check("run2_reach_exec_kij2", found, 1);
        ofv = 8'h7F;
        repeat (5) @(negedge clk);
        ofv = 8'hFF;
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            if (done_cnt > 0) found = 1'b1;
        end
        check("run2_done_seen", found, 1);
        repeat (6) @(negedge clk);
        tr_en = 1'b0;
        check("run2_single_done", done_cnt, 1);
        check("run2_idle_after", bus.busy_o, 0);

        // weight load of kij 2: addresses 1040..1047, l0_wr one cycle later, then 8 load cycles
        idx = -1;
        for (int i = 0; i < tr_n; i++)
            if (idx < 0 && tr_inst[i][19] == 1'b0 && tr_inst[i][17:7] == 11'd1040) idx = i;
        check("wload_kij2_found", idx >= 0, 1);
        if (idx >= 0 && idx + 17 < tr_n) begin
            bad = 0;
            for (int j = 0; j < 8; j++)
                if (tr_inst[idx+j][19] !== 1'b0 || tr_inst[idx+j][17:7] !== 11'(1040 + j)) bad++;
            check("wload_addr_seq", bad, 0);
            bad = 0;
            if (tr_inst[idx][2] !== 1'b0) bad++;
            for (int j = 1; j <= 8; j++) if (tr_inst[idx+j][2] !== 1'b1) bad++;
            if (tr_inst[idx+9][2] !== 1'b0) bad++;
            check("wload_l0wr_lag", bad, 0);
            bad = 0;
            if (tr_inst[idx+8][0] !== 1'b0) bad++;
            for (int j = 9; j <= 16; j++) if (tr_inst[idx+j][3] !== 1'b1 || tr_inst[idx+j][0] !== 1'b1) bad++;
            if (tr_inst[idx+17][0] !== 1'b0) bad++;
            check("wload_load_window", bad, 0);
        end

        // first execute pass: A_xmem 0..35, control bits lag by one for 36 cycles
        idx = -1;
        for (int i = 0; i < tr_n; i++) if (idx < 0 && tr_inst[i][1] == 1'b1) idx = i;
        check("exec_found", idx >= 1, 1);
        if (idx >= 1 && idx + 36 < tr_n) begin
            bad = 0;
            for (int j = 0; j < 36; j++)
                if (tr_inst[idx-1+j][19] !== 1'b0 || tr_inst[idx-1+j][17:7] !== 11'(j)) bad++;
            if (tr_inst[idx+35][19] !== 1'b1) bad++;
            check("exec_addr_seq", bad, 0);
            bad = 0;
            for (int j = 0; j < 36; j++) if (tr_inst[idx+j][3:1] !== 3'b111) bad++;
            if (tr_inst[idx+36][3:1] !== 3'b000) bad++;
            check("exec_ctrl_window", bad, 0);
        end

        // no reads while a column is not valid; every write follows a read, addresses in order
        bad = 0;
        for (int i = 0; i < tr_n; i++) if (tr_val[i] == 8'h7F && tr_inst[i][6]) bad++;
        check("bp_no_read_partial", bad, 0);
        nw = 0; bad = 0; last_w = -1;
        for (int i = 1; i < tr_n; i++) begin
            if (tr_inst[i][32] == 1'b0 && tr_inst[i][31] == 1'b0) begin
                if (nw < 324) begin
                    if (tr_inst[i][30:20] !== 11'(nw) || tr_inst[i-1][6] !== 1'b1) bad++;
                    if (nw == 72) check("bp_kij2_first_write", tr_inst[i][30:20], 72);
                    if (nw == 107) check("bp_kij2_last_write", tr_inst[i][30:20], 107);
                end
                nw++;
                last_w = i;
            end
        end
        check("drain_write_order", bad, 0);
`ifdef SEQ_ACC_EN
        check("pmem_write_count", nw, 360);
        check("last_write_addr", last_w >= 0 ? tr_inst[last_w][30:20] : 0, 359);
        idx = -1;
        for (int i = 0; i < tr_n; i++) if (idx < 0 && tr_inst[i][33] == 1'b1) idx = i;
        check("acc_found", idx >= 0, 1);
        if (idx >= 0 && idx + 9 < tr_n) begin
            bad = 0;
            for (int k = 0; k < 9; k++)
                if (tr_inst[idx+k][33:31] !== 3'b101 || tr_inst[idx+k][30:20] !== 11'(36 * k)) bad++;
            check("acc_out0_reads", bad, 0);
            check("acc_out0_write", {tr_inst[idx+9][33:31], tr_inst[idx+9][30:20]}, {3'b100, 11'd324});
        end
`else
        check("pmem_write_count", nw, 324);
        check("last_write_addr", last_w >= 0 ? tr_inst[last_w][30:20] : 0, 323);
        bad = 0;
        for (int i = 0; i < tr_n; i++) if (tr_inst[i][33]) bad++;
        check("acc_bit_tied_low", bad, 0);
`endif
        check("done_after_last_write", (last_w >= 0 && last_w + 1 < tr_n) ? tr_done[last_w+1] : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
